chroni_line_writer: RTL

CHRONI_LINE_WRITER -- requirements
Module: chroni_line_writer

---
 rtl/chroni_line_writer_pkg.sv | 17 +
 rtl/chroni_line_writer_if.sv | 22 ++
 rtl/chroni_glyph_shifter.sv | 42 ++++
 rtl/chroni_line_writer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/chroni_line_writer_pkg.sv
// Shared constants and FSM state type for the chroni text-mode line writer.
package chroni_pkg;

    localparam int TEXT_COLS     = 80;
    localparam int TEXT_ROWS     = 60;
    localparam int FONT_H        = 8;
    localparam int LINE_BUF_SIZE = 640;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_CHAR,
        S_REQ_FONT,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/chroni_line_writer_if.sv
// VRAM read port and line-buffer write port of the line writer.
interface chroni_line_writer_if;

    logic        vram_rd;
    logic [15:0] vram_addr;
    logic [7:0]  vram_data;
    logic        vram_valid;
    logic        buf_we;
    logic [10:0] buf_addr;
    logic [7:0]  buf_data;

    modport master (
        output vram_rd, vram_addr, buf_we, buf_addr, buf_data,
        input  vram_data, vram_valid
    );

    modport slave (
        input  vram_rd, vram_addr, buf_we, buf_addr, buf_data,
        output vram_data, vram_valid
    );

endinterface

// File: rtl/chroni_glyph_shifter.sv
// Holds one glyph row and shifts it out MSB-first, one pixel per shift.
module chroni_glyph_shifter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] byte_i,
    output logic       pix_o,
    output logic [2:0] idx_o,
    output logic       last_o
);

    logic [7:0] sh_q, sh_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sh_d  = byte_i;
            cnt_d = 3'd0;
        end else if (shift_i) begin
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_q  <= 8'd0;
            cnt_q <= 3'd0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign pix_o  = sh_q[7];
    assign idx_o  = cnt_q;
    assign last_o = shift_i && (cnt_q == 3'd7);

endmodule

// File: rtl/chroni_line_writer.sv
// Renders one 8x8 text scanline per render_start into alternating line-buffer halves.
module chroni_line_writer
    import chroni_pkg::*;
#(
    parameter int NUM_COLS = TEXT_COLS
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 render_reset,
    input  logic                 render_start,
    input  logic [15:0]          text_base,
    input  logic [15:0]          font_base,
    chroni_line_writer_if.master bus,
    output logic                 busy,
    output logic                 line_done
);

    localparam logic [6:0] LAST_COL = 7'(NUM_COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(TEXT_ROWS - 1);
    localparam logic [2:0] LAST_SCN = 3'(FONT_H - 1);

    state_t     state_q, state_d;
    logic [5:0] row_q, row_d;
    logic [2:0] scan_q, scan_d;
    logic [6:0] col_q, col_d;
    logic       half_q, half_d;
    logic [7:0] char_q, char_d;

    logic        sh_pix, sh_last;
    logic [2:0]  sh_idx;
    logic [15:0] text_addr, font_addr;
    logic [10:0] pix_addr;

    // Address arithmetic wraps naturally at 16 bits.
    assign text_addr = text_base + 16'(row_q) * 16'(TEXT_COLS) + 16'(col_q);
    assign font_addr = font_base + {5'b0, char_q, 3'b0} + 16'(scan_q);
    assign pix_addr  = (half_q ? 11'(LINE_BUF_SIZE) : 11'd0)
                     + {1'b0, col_q, 3'b0} + 11'(sh_idx);

    chroni_glyph_shifter u_shifter (
        .clk_i   (sys_clk),
        .rst_i   (reset),
        .load_i  ((state_q == S_REQ_FONT) && bus.vram_valid && !render_reset),
        .shift_i (state_q == S_WRITE),
        .byte_i  (bus.vram_data),
        .pix_o   (sh_pix),
        .idx_o   (sh_idx),
        .last_o  (sh_last)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            scan_q  <= '0;
            col_q   <= '0;
            half_q  <= 1'b0;
            char_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            scan_q  <= scan_d;
            col_q   <= col_d;
            half_q  <= half_d;
            char_q  <= char_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        scan_d  = scan_q;
        col_d   = col_q;
        half_d  = half_q;
        char_d  = char_q;
        if (render_reset) begin
            state_d = S_IDLE;
            row_d   = '0;
            scan_d  = '0;
            col_d   = '0;
            half_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (render_start) begin
                    state_d = S_REQ_CHAR;
                    col_d   = '0;
                end
                S_REQ_CHAR: if (bus.vram_valid) begin
                    char_d  = bus.vram_data;
                    state_d = S_REQ_FONT;
                end
                S_REQ_FONT: if (bus.vram_valid) state_d = S_WRITE;
                S_WRITE: if (sh_last) begin
                    if (col_q == LAST_COL) begin
                        state_d = S_DONE;
                    end else begin
                        col_d   = col_q + 7'd1;
                        state_d = S_REQ_CHAR;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    half_d  = ~half_q;
                    scan_d  = scan_q + 3'd1;
                    if (scan_q == LAST_SCN)
                        row_d = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.vram_rd   = 1'b0;
        bus.vram_addr = '0;
        bus.buf_we    = 1'b0;
        bus.buf_addr  = '0;
        bus.buf_data  = '0;
        busy          = 1'b0;
        line_done     = 1'b0;
        case (state_q)
            S_REQ_CHAR: begin
                bus.vram_rd   = 1'b1;
                bus.vram_addr = text_addr;
                busy          = 1'b1;
            end
            S_REQ_FONT: begin
                bus.vram_rd   = 1'b1;
                bus.vram_addr = font_addr;
                busy          = 1'b1;
            end
            S_WRITE: begin
                bus.buf_we   = 1'b1;
                bus.buf_addr = pix_addr;
                bus.buf_data = {7'b0, sh_pix};
                busy         = 1'b1;
            end
            // An abort landing on the final cycle suppresses the completion pulse.
            S_DONE: line_done = !render_reset;
            default: ;
        endcase
    end

endmodule
